// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a captured word out MSB first,
// holding each bit for HOLD cycles, with optional seamless repeat.
module pattern_tx #(
    parameter int   WIDTH    = 16,
    parameter int   HOLD     = 4,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             repeat_req,
    input  logic             abort,
    output logic             sig_out,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             sig_q, sig_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rot;

    always_comb begin
        // Rotating left means a full word restores the captured value,
        // so a repeat needs no second copy of the word.
        rot     = (shift_q << 1) | (shift_q >> (WIDTH - 1));
        state_d = state_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        shift_d = shift_q;
        sig_d   = sig_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load && !abort) begin
                    state_d = SEND;
                    shift_d = data;
                    bit_d   = '0;
                    hold_d  = '0;
                    sig_d   = data[WIDTH-1];
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                    bit_d   = '0;
                    hold_d  = '0;
                    sig_d   = IDLE_LVL;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    hold_d  = '0;
                    shift_d = rot;
                    sig_d   = rot[WIDTH-1];
                    if (bit_q != BIT_LAST) begin
                        bit_d = bit_q + 1'b1;
                    end else if (repeat_req) begin
                        bit_d = '0;
                    end else begin
                        state_d = IDLE;
                        bit_d   = '0;
                        sig_d   = IDLE_LVL;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            hold_q  <= '0;
            shift_q <= '0;
            sig_q   <= IDLE_LVL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
            sig_q   <= sig_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sig_out = sig_q;
    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: directed scenarios plus random traffic against
// a word/position reference model, on a default and a narrow instance.
module tb_pattern_tx;

    logic        clk;
    logic        reset;
    logic        load, rpt, abort;
    logic [15:0] data;
    logic        load1, rpt1, abort1;
    logic [7:0]  data1;
    logic        sig0, ready0, busy0, done0;
    logic        sig1, ready1, busy1, done1;
    logic [3:0]  o0, o1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        active;
        logic        done;
        int          pos;
        logic [15:0] word;
    } mdl_t;

    mdl_t m0, m1;

    pattern_tx dut0 (
        .clock(clk), .reset(reset), .load(load), .data(data),
        .repeat_req(rpt), .abort(abort), .sig_out(sig0),
        .ready(ready0), .busy(busy0), .done(done0)
    );

    pattern_tx #(.WIDTH(8), .HOLD(1), .IDLE_LVL(1'b1)) dut1 (
        .clock(clk), .reset(reset), .load(load1), .data(data1),
        .repeat_req(rpt1), .abort(abort1), .sig_out(sig1),
        .ready(ready1), .busy(busy1), .done(done1)
    );

    assign o0 = {sig0, busy0, ready0, done0};
    assign o1 = {sig1, busy1, ready1, done1};

    always #5 clk = ~clk;

    // Word is active for w*h cycles; position pos shows bit w-1-pos/h.
    function automatic mdl_t mnext(mdl_t m, int w, int h, logic rst,
                                   logic ld, logic [15:0] d,
                                   logic rp, logic ab);
        mdl_t n;
        n = m;
        n.done = 1'b0;
        if (rst) begin
            n.active = 1'b0;
            n.pos = 0;
        end else if (m.active) begin
            if (ab) begin
                n.active = 1'b0;
            end else if (m.pos == w * h - 1) begin
                if (rp) n.pos = 0;
                else begin
                    n.active = 1'b0;
                    n.done = 1'b1;
                end
            end else begin
                n.pos = m.pos + 1;
            end
        end else if (ld && !ab) begin
            n.active = 1'b1;
            n.pos = 0;
            n.word = d;
        end
        return n;
    endfunction

    function automatic logic [3:0] mout(mdl_t m, int w, int h, logic idl);
        logic [3:0] r;
        r[3] = m.active ? m.word[w - 1 - m.pos / h] : idl;
        r[2] = m.active;
        r[1] = !m.active;
        r[0] = m.done;
        return r;
    endfunction

    function automatic logic [3:0] e0();
        return mout(m0, 16, 4, 1'b0);
    endfunction

    function automatic logic [3:0] e1();
        return mout(m1, 8, 1, 1'b1);
    endfunction

    task automatic step();
        @(posedge clk);
        m0 = mnext(m0, 16, 4, reset, load, data, rpt, abort);
        m1 = mnext(m1, 8, 1, reset, load1, {8'h00, data1}, rpt1, abort1);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load = 1'b1;
        load1 = 1'b1;
        data = 16'hFFFF;
        data1 = 8'h00;
        step();
        step();
        load = 1'b0;
        load1 = 1'b0;
        tests++;
        if (o0 !== 4'b0010) begin
            fails++;
            $display("FAIL reset0 got=%b exp=0010", o0);
        end
        tests++;
        if (o1 !== 4'b1010) begin
            fails++;
            $display("FAIL reset1 got=%b exp=1010", o1);
        end
        reset = 1'b0;
        step();
        tests++;
        if (o0 !== 4'b0010 || o1 !== 4'b1010) begin
            fails++;
            $display("FAIL reset_idle got=%b/%b exp=0010/1010", o0, o1);
        end
    endtask

    task automatic test_basic();
        logic [15:0] w;
        int done_at;
        w = 16'h1D7D;
        done_at = 0;
        data = w;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int c = 1; c <= 68; c++) begin
            if (c > 1) step();
            data = 16'($urandom);
            tests++;
            if (o0 !== e0()) begin
                fails++;
                $display("FAIL basic c=%0d got=%b exp=%b", c, o0, e0());
            end
            if (c <= 64) begin
                tests++;
                if (o0[3] !== w[15 - (c - 1) / 4]) begin
                    fails++;
                    $display("FAIL basic_bit c=%0d got=%b exp=%b",
                             c, o0[3], w[15 - (c - 1) / 4]);
                end
            end
            if (o0[0] && done_at == 0) done_at = c;
        end
        tests++;
        if (done_at != 65) begin
            fails++;
            $display("FAIL basic_done got=%0d exp=65", done_at);
        end
    endtask

    task automatic test_repeat();
        int done_at;
        logic want;
        done_at = 0;
        data = 16'h8001;
        rpt = 1'b1;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) step();
            if (c == 150) rpt = 1'b0;
            tests++;
            if (o0 !== e0()) begin
                fails++;
                $display("FAIL repeat c=%0d got=%b exp=%b", c, o0, e0());
            end
            if (c <= 192) begin
                want = ((c - 1) % 64 < 4) || ((c - 1) % 64 >= 60);
                tests++;
                if (o0[3] !== want || o0[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL repeat_pat c=%0d got=%b/%b exp=%b/0",
                             c, o0[3], o0[0], want);
                end
            end
            if (o0[0] && done_at == 0) done_at = c;
        end
        tests++;
        if (done_at != 193) begin
            fails++;
            $display("FAIL repeat_done got=%0d exp=193", done_at);
        end
    endtask

    task automatic test_abort();
        logic [15:0] w2;
        int done_at;
        done_at = 0;
        data = 16'($urandom);
        load = 1'b1;
        step();
        load = 1'b0;
        for (int c = 2; c <= 20; c++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++;
        if (o0 !== 4'b0010 || o0 !== e0()) begin
            fails++;
            $display("FAIL abort got=%b exp=0010", o0);
        end
        step();
        tests++;
        if (o0 !== 4'b0010) begin
            fails++;
            $display("FAIL abort_idle got=%b exp=0010", o0);
        end
        w2 = 16'($urandom) ^ 16'h8000;
        data = w2;
        load = 1'b1;
        step();
        load = 1'b0;
        tests++;
        if (o0[3] !== w2[15] || o0[2] !== 1'b1) begin
            fails++;
            $display("FAIL abort_restart got=%b exp=%b1", o0[3:2], w2[15]);
        end
        for (int c = 2; c <= 66; c++) begin
            step();
            tests++;
            if (o0 !== e0()) begin
                fails++;
                $display("FAIL abort_word c=%0d got=%b exp=%b", c, o0, e0());
            end
            if (o0[0] && done_at == 0) done_at = c;
        end
        tests++;
        if (done_at != 65) begin
            fails++;
            $display("FAIL abort_done got=%0d exp=65", done_at);
        end
    endtask

    task automatic test_load_ignored();
        logic [15:0] w1, w2;
        int done_at;
        w1 = 16'($urandom) & 16'h7FFE;
        w2 = 16'($urandom) | 16'h8000;
        done_at = 0;
        data = w1;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int c = 1; c <= 65; c++) begin
            if (c > 1) step();
            load = (c == 10);
            data = (c == 10) ? 16'hFFFF : w1;
            tests++;
            if (c <= 64 && o0 !== {w1[15 - (c - 1) / 4], 3'b100}) begin
                fails++;
                $display("FAIL ignore c=%0d got=%b exp=%b",
                         c, o0, {w1[15 - (c - 1) / 4], 3'b100});
            end
            if (c == 65 && o0 !== 4'b0011) begin
                fails++;
                $display("FAIL ignore_done got=%b exp=0011", o0);
            end
        end
        data = w2;
        load = 1'b1;
        step();
        load = 1'b0;
        tests++;
        if (o0 !== 4'b1100 || o0 !== e0()) begin
            fails++;
            $display("FAIL b2b_start got=%b exp=1100", o0);
        end
        for (int c = 2; c <= 66; c++) begin
            step();
            tests++;
            if (o0 !== e0()) begin
                fails++;
                $display("FAIL b2b c=%0d got=%b exp=%b", c, o0, e0());
            end
            if (o0[0] && done_at == 0) done_at = c;
        end
        tests++;
        if (done_at != 65) begin
            fails++;
            $display("FAIL b2b_done got=%0d exp=65", done_at);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        data = 16'($urandom) | 16'h0001;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int c = 2; c <= 30; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if (o0 !== 4'b0010) begin
            fails++;
            $display("FAIL rst_mid got=%b exp=0010", o0);
        end
        for (int c = 0; c < 70; c++) begin
            step();
            if (o0 !== 4'b0010) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL rst_mid_quiet got=%0d bad cycles exp=0", seen);
        end
        abort = 1'b1;
        load = 1'b1;
        step();
        abort = 1'b0;
        load = 1'b0;
        tests++;
        if (o0 !== 4'b0010) begin
            fails++;
            $display("FAIL abort_load got=%b exp=0010", o0);
        end
        step();
        tests++;
        if (o0 !== 4'b0010) begin
            fails++;
            $display("FAIL abort_load2 got=%b exp=0010", o0);
        end
    endtask

    task automatic test_rpt_abort();
        data = 16'($urandom);
        rpt = 1'b1;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int c = 2; c <= 64; c++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        rpt = 1'b0;
        tests++;
        if (o0 !== 4'b0010) begin
            fails++;
            $display("FAIL rpt_abort got=%b exp=0010", o0);
        end
        step();
        tests++;
        if (o0 !== 4'b0010) begin
            fails++;
            $display("FAIL rpt_abort2 got=%b exp=0010", o0);
        end
    endtask

    task automatic test_hold1();
        logic [7:0] w;
        int done_at;
        w = 8'hA5;
        done_at = 0;
        data1 = w;
        load1 = 1'b1;
        step();
        load1 = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) step();
            tests++;
            if (o1 !== e1()) begin
                fails++;
                $display("FAIL hold1 c=%0d got=%b exp=%b", c, o1, e1());
            end
            if (c <= 8) begin
                tests++;
                if (o1[3] !== w[8 - c]) begin
                    fails++;
                    $display("FAIL hold1_bit c=%0d got=%b exp=%b",
                             c, o1[3], w[8 - c]);
                end
            end
            if (o1[0] && done_at == 0) done_at = c;
        end
        tests++;
        if (done_at != 9) begin
            fails++;
            $display("FAIL hold1_done got=%0d exp=9", done_at);
        end
    endtask

    task automatic test_random();
        int bad0, bad1;
        bad0 = 0;
        bad1 = 0;
        for (int c = 0; c < 3000; c++) begin
            reset  = ($urandom_range(0, 299) == 0);
            load   = ($urandom_range(0, 2) == 0);
            data   = 16'($urandom);
            rpt    = $urandom_range(0, 1) == 1;
            abort  = ($urandom_range(0, 79) == 0);
            load1  = ($urandom_range(0, 2) == 0);
            data1  = 8'($urandom);
            rpt1   = $urandom_range(0, 1) == 1;
            abort1 = ($urandom_range(0, 19) == 0);
            step();
            tests++;
            if (o0 !== e0()) begin
                fails++;
                if (bad0 < 5)
                    $display("FAIL rand0 c=%0d got=%b exp=%b", c, o0, e0());
                bad0++;
            end
            tests++;
            if (o1 !== e1()) begin
                fails++;
                if (bad1 < 5)
                    $display("FAIL rand1 c=%0d got=%b exp=%b", c, o1, e1());
                bad1++;
            end
        end
        reset = 1'b0;
        load = 1'b0;
        rpt = 1'b0;
        abort = 1'b0;
        load1 = 1'b0;
        rpt1 = 1'b0;
        abort1 = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        load = 1'b0;
        rpt = 1'b0;
        abort = 1'b0;
        data = '0;
        load1 = 1'b0;
        rpt1 = 1'b0;
        abort1 = 1'b0;
        data1 = '0;
        m0 = '{active: 1'b0, done: 1'b0, pos: 0, word: 16'h0};
        m1 = '{active: 1'b0, done: 1'b0, pos: 0, word: 16'h0};
        test_reset();
        test_basic();
        test_repeat();
        test_abort();
        test_load_ignored();
        test_reset_mid();
        test_rpt_abort();
        test_hold1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
